// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// Optional parity support is selected with UART_RX_PARITY_EN.
package uart_pkg;

  localparam int DATA_BITS       = 8;
  localparam int ACQ_PER_BIT_DEF = 16;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;
`endif

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Line synchronizer, per-bit strobe counter and 3-sample vote.
// Builds with or without UART_RX_PARITY_EN (no difference here).
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int ACQ_PER_BIT = ACQ_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic acq_i,
  input  logic rx_i,
  input  logic en_i,
  input  logic clr_i,
  output logic rx_o,
  output logic mid_o,
  output logic vote_o,
  output logic wrap_o
);

  localparam logic [3:0] MID  = 4'(ACQ_PER_BIT / 2);
  localparam logic [3:0] MIDM = 4'(ACQ_PER_BIT / 2 - 1);
  localparam logic [3:0] MIDP = 4'(ACQ_PER_BIT / 2 + 1);
  localparam logic [3:0] LAST = 4'(ACQ_PER_BIT - 1);

  logic [1:0] sync_q, sync_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] smp_q, smp_d;
  logic       tick;

  assign rx_o = sync_q[1];
  assign tick = acq_i & en_i;

  always_comb begin
    sync_d = {sync_q[0], rx_i};
    cnt_d  = cnt_q;
    smp_d  = smp_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = (cnt_q == LAST) ? 4'd0 : cnt_q + 4'd1;
      if (cnt_q == MIDM) smp_d[0] = rx_o;
      if (cnt_q == MID)  smp_d[1] = rx_o;
    end
  end

  // third sample is the live line at MID+1
  assign mid_o  = tick & (cnt_q == MIDP);
  assign wrap_o = tick & (cnt_q == LAST);
  assign vote_o = maj3(smp_q[0], smp_q[1], rx_o);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      smp_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      smp_q  <= smp_d;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start + 8 data (+ parity) + stop, valid/ready output.
// Define UART_RX_PARITY_EN to include the parity bit and check.
module uart_rx_core #(
  parameter int ACQ_PER_BIT = uart_pkg::ACQ_PER_BIT_DEF,
  parameter int DATA_BITS   = uart_pkg::DATA_BITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       AcqSig_i,
  input  logic       Rx_i,
  input  logic       ParityEn_i,
  input  logic       ParityOdd_i,
  output logic [7:0] Data_o,
  output logic       DataValid_o,
  input  logic       DataReady_i,
  output logic       FrameErr_o,
  output logic       ParityErr_o,
  output logic       Overrun_o,
  output logic       Busy_o
);

  import uart_pkg::*;

  localparam int          BW   = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LIDX = BW'(DATA_BITS - 1);

  rx_state_e state_q, state_d;
  logic [BW-1:0] idx_q, idx_d;
  logic [7:0]    shf_q, shf_d;
  logic          ld_q, ld_d;
  logic [7:0]    ldat_q, ldat_d;
  logic          lfe_q, lfe_d;
  logic [7:0]    data_q, data_d;
  logic          val_q, val_d;
  logic          fe_q, fe_d;
  logic          ovr_q, ovr_d;
  logic          rx_s, mid, vote, wrap, clr, en;
  logic          start_det;

  uart_bit_sampler #(
    .ACQ_PER_BIT(ACQ_PER_BIT)
  ) u_smp (
    .clk   (clk),
    .rst   (rst),
    .acq_i (AcqSig_i),
    .rx_i  (Rx_i),
    .en_i  (en),
    .clr_i (clr),
    .rx_o  (rx_s),
    .mid_o (mid),
    .vote_o(vote),
    .wrap_o(wrap)
  );

  assign en        = (state_q != ST_IDLE);
  assign start_det = (state_q == ST_IDLE) & AcqSig_i & ~rx_s;
  assign clr       = start_det;

`ifdef UART_RX_PARITY_EN
  logic pen_q, pen_d;
  logic podd_q, podd_d;
  logic perr_q, perr_d;
  logic lpe_q, lpe_d;
  logic pe_q, pe_d;

  always_comb begin
    pen_d  = pen_q;
    podd_d = podd_q;
    perr_d = perr_q;
    lpe_d  = lpe_q;
    if (start_det) begin
      pen_d  = ParityEn_i;
      podd_d = ParityOdd_i;
      perr_d = 1'b0;
    end
    if (state_q == ST_PARITY && mid)
      perr_d = ((^shf_q) ^ vote) != podd_q;
    if (state_q == ST_STOP && mid)
      lpe_d = perr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pen_q  <= 1'b0;
      podd_q <= 1'b0;
      perr_q <= 1'b0;
      lpe_q  <= 1'b0;
    end else begin
      pen_q  <= pen_d;
      podd_q <= podd_d;
      perr_q <= perr_d;
      lpe_q  <= lpe_d;
    end
  end
`else
  logic unused_par;
  assign unused_par = ParityEn_i ^ ParityOdd_i;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shf_d   = shf_q;
    ld_d    = 1'b0;
    ldat_d  = ldat_q;
    lfe_d   = lfe_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_det) begin
          state_d = ST_START;
          idx_d   = '0;
        end
      end
      ST_START: begin
        if (mid && vote) state_d = ST_IDLE;
        else if (wrap)   state_d = ST_DATA;
      end
      ST_DATA: begin
        if (mid) shf_d = {vote, shf_q[7:1]};
        if (wrap) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LIDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = pen_q ? ST_PARITY : ST_STOP;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (wrap) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // leave at the vote so the next start edge is caught in time
        if (mid) begin
          ld_d    = 1'b1;
          ldat_d  = shf_q;
          lfe_d   = ~vote;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d = data_q;
    val_d  = val_q;
    fe_d   = fe_q;
    ovr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_d   = pe_q;
`endif
    if (ld_q) begin
      if (!val_q || DataReady_i) begin
        data_d = ldat_q;
        fe_d   = lfe_q;
        val_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
        pe_d   = lpe_q;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (val_q && DataReady_i) begin
      val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      shf_q   <= '0;
      ld_q    <= 1'b0;
      ldat_q  <= '0;
      lfe_q   <= 1'b0;
      data_q  <= '0;
      val_q   <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shf_q   <= shf_d;
      ld_q    <= ld_d;
      ldat_q  <= ldat_d;
      lfe_q   <= lfe_d;
      data_q  <= data_d;
      val_q   <= val_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) pe_q <= 1'b0;
    else     pe_q <= pe_d;
  end
  assign ParityErr_o = pe_q;
`else
  assign ParityErr_o = 1'b0;
`endif

  assign Data_o      = data_q;
  assign DataValid_o = val_q;
  assign FrameErr_o  = fe_q;
  assign Overrun_o   = ovr_q;
  assign Busy_o      = en;

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized frame-level bench for uart_rx_core with a byte scoreboard.
// Parity frames are exercised when UART_RX_PARITY_EN is defined.
module tb_uart_rx_core;

`ifdef UART_RX_PARITY_EN
  localparam bit PB = 1'b1;
`else
  localparam bit PB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       AcqSig_i = 1'b0;
  logic       Rx_i = 1'b1;
  logic       ParityEn_i = 1'b0;
  logic       ParityOdd_i = 1'b0;
  logic [7:0] Data_o;
  logic       DataValid_o;
  logic       DataReady_i = 1'b1;
  logic       FrameErr_o;
  logic       ParityErr_o;
  logic       Overrun_o;
  logic       Busy_o;

  int checks = 0;
  int failures = 0;
  int ovr_cnt = 0;
  int rx_cnt = 0;
  int pushed = 0;
  int ready_mode = 1;
  logic [9:0] exp_q[$];
  logic prev_acc = 1'b0;

  uart_rx_core #(.ACQ_PER_BIT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .AcqSig_i   (AcqSig_i),
    .Rx_i       (Rx_i),
    .ParityEn_i (ParityEn_i),
    .ParityOdd_i(ParityOdd_i),
    .Data_o     (Data_o),
    .DataValid_o(DataValid_o),
    .DataReady_i(DataReady_i),
    .FrameErr_o (FrameErr_o),
    .ParityErr_o(ParityErr_o),
    .Overrun_o  (Overrun_o),
    .Busy_o     (Busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      AcqSig_i = (ph == 0);
      ph = (ph == 3) ? 0 : ph + 1;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 2) DataReady_i = 1'($urandom_range(0, 1));
      else DataReady_i = (ready_mode == 1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    if (prev_acc) chk("valid_clr", DataValid_o, 0);
    if (Overrun_o === 1'b1) ovr_cnt++;
    prev_acc = DataValid_o && DataReady_i;
    if (prev_acc) begin
      chk("byte_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("data", Data_o, e[9:2]);
        chk("frame_err", FrameErr_o, e[1]);
        chk("parity_err", ParityErr_o, e[0]);
        rx_cnt++;
      end
    end
  end

  task automatic wait_strobe();
    do @(posedge clk); while (AcqSig_i !== 1'b1);
  endtask

  task automatic send_bit(input logic b, input int n);
    @(negedge clk);
    Rx_i = b;
    repeat (n) wait_strobe();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen,
                            input logic podd, input logic pflip,
                            input logic stopb, input bit push,
                            input int gap);
    logic p;
    ParityEn_i  = pen;
    ParityOdd_i = podd;
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(d[i], 16);
    p = podd ? ~(^d) : (^d);
    if (PB && pen) send_bit(p ^ pflip, 16);
    if (push) begin
      exp_q.push_back({d, ~stopb, PB & pen & pflip});
      pushed++;
    end
    send_bit(stopb, 16);
    if (gap > 0) send_bit(1'b1, gap);
  endtask

  initial begin
    int ovr0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", DataValid_o, 0);
    chk("rst_data", Data_o, 0);
    chk("rst_busy", Busy_o, 0);
    chk("rst_ferr", FrameErr_o, 0);
    chk("rst_perr", ParityErr_o, 0);
    chk("rst_ovr", Overrun_o, 0);
    rst = 1'b0;
    send_bit(1'b1, 4);

    send_frame(8'h55, 0, 0, 0, 1, 1, 20);
`ifdef UART_RX_PARITY_EN
    send_frame(8'hA3, 1, 1, 0, 1, 1, 20);
    send_frame(8'hA3, 1, 1, 1, 1, 1, 20);
`else
    send_frame(8'hA3, 1, 1, 0, 1, 1, 20);
`endif

    send_bit(1'b0, 2);
    @(negedge clk);
    chk("fs_busy_hi", Busy_o, 1);
    send_bit(1'b0, 3);
    send_bit(1'b1, 20);
    @(negedge clk);
    chk("fs_busy_lo", Busy_o, 0);
    chk("fs_valid", DataValid_o, 0);

    send_frame(8'h3C, 0, 0, 0, 0, 1, 20);

    ready_mode = 0;
    ovr0 = ovr_cnt;
    send_frame(8'h11, 0, 0, 0, 1, 1, 0);
    send_frame(8'h22, 0, 0, 0, 1, 0, 20);
    @(negedge clk);
    chk("ovr_pulses", ovr_cnt - ovr0, 1);
    chk("ovr_data", Data_o, 8'h11);
    chk("ovr_valid", DataValid_o, 1);
    ready_mode = 1;
    send_bit(1'b1, 4);

    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 16);
    send_bit(1'b1, 5);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", Busy_o, 0);
    chk("rst_mid_valid", DataValid_o, 0);
    send_bit(1'b1, 16 * 5 + 20);
    send_frame(8'h0F, 0, 0, 0, 1, 1, 20);

    ready_mode = 2;
    for (int k = 0; k < 20; k++) begin
      send_frame(8'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 7) != 0), 1, 20);
    end
    ready_mode = 1;
    send_bit(1'b1, 8);

    chk("exp_q_empty", exp_q.size(), 0);
    chk("rx_count", rx_cnt, pushed);
    chk("ovr_total", ovr_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
